fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter STACK_DEPTH, default 8: number of return-stack entries, power of two, 2..16.
REQ-002 Parameter RESET_PC, default 10'h000: first fetch address after reset.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst  input  1: reset, asynchronous and active-high.
REQ-005 rom_addr  output  10: instruction ROM address, combinationally equal to the PC register.
REQ-006 rom_data  input  16: ROM word for rom_addr, valid in the same cycle (combinational ROM).
REQ-007 instr  output  16: registered instruction word presented to decode.
REQ-008 instr_pc  output  10: address from which instr was fetched.
REQ-009 instr_valid  output  1: instr/instr_pc hold a valid instruction.
REQ-010 instr_ready  input  1: decode accepts instr this cycle.
REQ-011 redirect  input  1: execute-stage PC override request.
REQ-012 redirect_pc  input  10: target address when redirect=1.
REQ-013 stack_err  output  1: sticky flag, return-stack overflow or underflow.

Function
REQ-014 Advance condition: adv = (!instr_valid || instr_ready) && !redirect.
REQ-015 On adv: instr<=rom_data, instr_pc<=pc, instr_valid<=1, pc<=next_pc; fetch-to-output latency is 1 cycle.
REQ-016 When !adv and !redirect: pc, instr, instr_pc, instr_valid and the stack hold their values (stall).
REQ-017 next_pc decode uses rom_data[15:11] against OPCODE_JMP, OPCODE_CALL and OPCODE_RET from constants.sv; the target field is rom_data[10:1].
REQ-018 JMP: next_pc = target.
REQ-019 CALL: next_pc = target; push pc+1 (mod 1024) onto the return stack.
REQ-020 RET: next_pc = top of stack; pop.
REQ-021 All other opcodes: next_pc = pc+1; 10'h3FF wraps to 10'h000.
REQ-022 Redirect has highest priority: pc<=redirect_pc, instr_valid<=0 next cycle, no push/pop, instr/instr_pc unchanged.
REQ-023 CALL with stack full: jump taken, push discarded, stack_err<=1.
REQ-024 RET with stack empty: next_pc = 10'h000, stack_err<=1.
REQ-025 stack_err clears only on reset.
REQ-026 Stack pointer range 0..STACK_DEPTH; push and pop occur only on adv.

Reset
REQ-027 While rst=1: pc=RESET_PC, instr=16'h0000, instr_pc=10'h000, instr_valid=0, stack empty, stack_err=0, all applied asynchronously.
REQ-028 First instr_valid=1 occurs the first rising edge after rst deasserts, with instr_pc=RESET_PC.
REQ-029 Reset during a stall or redirect discards all in-flight state without side effects.

Configuration
REQ-030 Macro FETCH_RETSTACK_EN defined: return stack, CALL/RET handling and stack_err as in REQ-019..REQ-026.
REQ-031 FETCH_RETSTACK_EN undefined: no stack storage; CALL behaves as JMP (no push); RET yields next_pc = pc+1; stack_err tied to 0.

Verification
REQ-032 Program 0:MVL, 1:MVL, 2:CALL 0x100, 3:OUT, 4:JMP 4, 0x100:ADD, 0x101:RET with instr_ready=1 -> instr_pc sequence 0,1,2,0x100,0x101,3,4,4,4...; stack_err=0.
REQ-033 Hold instr_ready=0 for 3 cycles at instr_pc=2 -> instr and instr_pc stable, rom_addr stays 0x100, no push until accepted.
REQ-034 redirect=1 with redirect_pc=0x050 while instr_valid=1 -> next cycle instr_valid=0, rom_addr=0x050; cycle after, instr_pc=0x050.
REQ-035 Nine nested CALLs (STACK_DEPTH=8) -> ninth jump taken, stack_err=1; RET from empty stack -> rom_addr=0x000.
REQ-036 Sequential code at 0x3FF -> next instr_pc=0x000.
REQ-037 rst asserted mid-stall -> instr_valid=0 immediately, rom_addr=RESET_PC; build without FETCH_RETSTACK_EN, RET at 0x101 -> next instr_pc=0x102.

Source files
------------

// File: rtl/constants.sv
// rtl/constants.sv - shared instruction opcode constants
package constants_pkg;

  // Instruction word layout: [15:11] opcode, [10:1] target address, [0] unused by fetch
  localparam logic [4:0] OPCODE_JMP  = 5'b11000;
  localparam logic [4:0] OPCODE_CALL = 5'b11001;
  localparam logic [4:0] OPCODE_RET  = 5'b11010;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with optional return-address stack
//
// Purpose: holds the PC, fetches one word per cycle from a combinational ROM,
// presents it to decode through a valid/ready register stage and computes the
// next PC for JMP/CALL/RET. Execute can override the PC through redirect.
//
// Optional feature: define FETCH_RETSTACK_EN to build the return stack
// (CALL pushes, RET pops, stack_err flags overflow/underflow). Without it,
// CALL acts as JMP, RET falls through to pc+1 and stack_err is tied low.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rom_addr, rom_data  ROM address (the PC) and the word at that address
//   instr, instr_pc     registered instruction and the address it came from
//   instr_valid         instr/instr_pc hold a valid instruction
//   instr_ready         decode accepts instr this cycle
//   redirect            execute-stage PC override, target in redirect_pc
//   stack_err           sticky return-stack overflow/underflow flag
module fetch_unit
  import constants_pkg::*;
#(
  parameter int         STACK_DEPTH = 8,
  parameter logic [9:0] RESET_PC    = 10'h000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic [15:0] instr,
  output logic [9:0]  instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [9:0]  redirect_pc,
  output logic        stack_err
);

  logic [9:0] pc;
  logic [9:0] pc_inc;
  logic [9:0] next_pc;
  logic [4:0] opcode;
  logic [9:0] target;
  logic       adv;

  assign rom_addr = pc;
  assign pc_inc   = pc + 10'd1;   // 10-bit add wraps 0x3FF to 0x000
  assign opcode   = rom_data[15:11];
  assign target   = rom_data[10:1];

  // Redirect blocks advancing so no push/pop or output update happens with it
  assign adv = (!instr_valid || instr_ready) && !redirect;

`ifdef FETCH_RETSTACK_EN
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SP_W  = IDX_W + 1;

  logic [9:0]      stack [STACK_DEPTH];
  logic [SP_W-1:0] sp;          // number of occupied entries, 0..STACK_DEPTH
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            err_set;
  logic [IDX_W-1:0] top_idx;

  assign full    = (sp == SP_W'(STACK_DEPTH));
  assign empty   = (sp == '0);
  assign top_idx = IDX_W'(sp - 1'b1);

  always_comb begin
    next_pc = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    case (opcode)
      OPCODE_JMP: next_pc = target;
      OPCODE_CALL: begin
        // The jump is always taken; only the return address is lost when full
        next_pc = target;
        if (full) err_set = 1'b1;
        else      push    = 1'b1;
      end
      OPCODE_RET: begin
        if (empty) begin
          next_pc = 10'h000;
          err_set = 1'b1;
        end else begin
          next_pc = stack[top_idx];
          pop     = 1'b1;
        end
      end
      default: next_pc = pc_inc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp        <= '0;
      stack_err <= 1'b0;
    end else if (adv) begin
      if (push)    sp        <= sp + 1'b1;
      if (pop)     sp        <= sp - 1'b1;
      if (err_set) stack_err <= 1'b1;
    end
  end

  // Entries need no reset: sp alone defines which ones are live
  always_ff @(posedge clk) begin
    if (!rst && adv && push) stack[sp[IDX_W-1:0]] <= pc_inc;
  end
`else
  always_comb begin
    next_pc = pc_inc;
    if (opcode == OPCODE_JMP || opcode == OPCODE_CALL) next_pc = target;
  end

  assign stack_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      instr       <= 16'h0000;
      instr_pc    <= 10'h000;
      instr_valid <= 1'b0;
    end else if (redirect) begin
      pc          <= redirect_pc;
      instr_valid <= 1'b0;
    end else if (adv) begin
      instr       <= rom_data;
      instr_pc    <= pc;
      instr_valid <= 1'b1;
      pc          <= next_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
  import constants_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] instr;
  logic [9:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [9:0]  redirect_pc;
  logic        stack_err;

  logic [15:0] rom [1024];
  assign rom_data = rom[rom_addr];

  int checks = 0;
  int errors = 0;

  fetch_unit #(.STACK_DEPTH(8), .RESET_PC(10'h000)) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stack_err   (stack_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] enc(input logic [4:0] op, input logic [9:0] t);
    return {op, t, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset across one edge and releases it; the next edge fetches RESET_PC
  task automatic do_reset();
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 10'h000;
    instr_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [9:0] seq_exp [9];
  logic [9:0] after_ret_exp;
  logic       nest_err_exp;
  logic [9:0] empty_ret_addr_exp;

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 16'h0000;
    rom[10'h000] = enc(5'b00001, 10'h000);      // MVL
    rom[10'h001] = enc(5'b00001, 10'h000);      // MVL
    rom[10'h002] = enc(OPCODE_CALL, 10'h100);
    rom[10'h003] = enc(5'b00010, 10'h000);      // OUT
    rom[10'h004] = enc(OPCODE_JMP, 10'h004);
    rom[10'h100] = enc(5'b00011, 10'h000);      // ADD
    rom[10'h101] = enc(OPCODE_RET, 10'h000);
    for (int i = 0; i < 9; i++) rom[10'h200 + i] = enc(OPCODE_CALL, 10'(10'h201 + i));
    rom[10'h300] = enc(OPCODE_RET, 10'h000);

`ifdef FETCH_RETSTACK_EN
    seq_exp            = '{10'h000, 10'h001, 10'h002, 10'h100, 10'h101, 10'h003, 10'h004, 10'h004, 10'h004};
    after_ret_exp      = 10'h003;
    nest_err_exp       = 1'b1;
    empty_ret_addr_exp = 10'h000;
`else
    seq_exp            = '{10'h000, 10'h001, 10'h002, 10'h100, 10'h101, 10'h102, 10'h103, 10'h104, 10'h105};
    after_ret_exp      = 10'h102;
    nest_err_exp       = 1'b0;
    empty_ret_addr_exp = 10'h301;
`endif

    // Reset state
    rst = 1'b1; redirect = 1'b0; redirect_pc = 10'h000; instr_ready = 1'b1;
    #1;
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_rom_addr", 32'(rom_addr), 32'h000);
    check("rst_instr", 32'(instr), 32'h0000);
    check("rst_instr_pc", 32'(instr_pc), 32'h000);
    check("rst_stack_err", 32'(stack_err), 32'h0);

    // Main program flow with decode always ready
    do_reset();
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("seq_pc_%0d", i), 32'(instr_pc), 32'(seq_exp[i]));
      check($sformatf("seq_valid_%0d", i), 32'(instr_valid), 32'h1);
    end
    check("seq_stack_err", 32'(stack_err), 32'h0);

    // Decode stall while the CALL sits in the output register
    do_reset();
    tick(); tick(); tick();
    check("stall_entry_pc", 32'(instr_pc), 32'h002);
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_instr_pc", 32'(instr_pc), 32'h002);
      check("stall_instr", 32'(instr), 32'(enc(OPCODE_CALL, 10'h100)));
      check("stall_rom_addr", 32'(rom_addr), 32'h100);
    end
    instr_ready = 1'b1;
    tick(); check("stall_rel_0", 32'(instr_pc), 32'h100);
    tick(); check("stall_rel_1", 32'(instr_pc), 32'h101);
    tick(); check("stall_after_ret", 32'(instr_pc), 32'(after_ret_exp));

    // Redirect while holding a valid instruction
    do_reset();
    tick();
    check("redir_pre_valid", 32'(instr_valid), 32'h1);
    redirect = 1'b1; redirect_pc = 10'h050;
    tick();
    check("redir_valid", 32'(instr_valid), 32'h0);
    check("redir_rom_addr", 32'(rom_addr), 32'h050);
    check("redir_instr_pc_held", 32'(instr_pc), 32'h000);
    redirect = 1'b0;
    tick();
    check("redir_target_pc", 32'(instr_pc), 32'h050);
    check("redir_target_valid", 32'(instr_valid), 32'h1);

    // Sequential wrap at the top of the address space
    redirect = 1'b1; redirect_pc = 10'h3FF;
    tick();
    redirect = 1'b0;
    tick();
    check("wrap_pc_3ff", 32'(instr_pc), 32'h3FF);
    check("wrap_rom_addr", 32'(rom_addr), 32'h000);
    tick();
    check("wrap_next_pc", 32'(instr_pc), 32'h000);

    // Nine nested CALLs against an 8-entry stack
    do_reset();
    redirect = 1'b1; redirect_pc = 10'h200;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("nest8_rom_addr", 32'(rom_addr), 32'h208);
    check("nest8_stack_err", 32'(stack_err), 32'h0);
    tick();
    check("nest9_rom_addr", 32'(rom_addr), 32'h209);
    check("nest9_stack_err", 32'(stack_err), 32'(nest_err_exp));
    tick();
    check("nest_err_sticky", 32'(stack_err), 32'(nest_err_exp));

    // RET with an empty stack
    do_reset();
    check("empty_err_cleared", 32'(stack_err), 32'h0);
    redirect = 1'b1; redirect_pc = 10'h300;
    tick();
    redirect = 1'b0;
    tick();
    check("empty_ret_rom_addr", 32'(rom_addr), 32'(empty_ret_addr_exp));
    check("empty_ret_err", 32'(stack_err), 32'(nest_err_exp));

    // Asynchronous reset in the middle of a stall
    do_reset();
    tick(); tick();
    instr_ready = 1'b0;
    tick();
    check("mid_stall_valid", 32'(instr_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(instr_valid), 32'h0);
    check("async_rst_rom_addr", 32'(rom_addr), 32'h000);
    check("async_rst_instr_pc", 32'(instr_pc), 32'h000);
    check("async_rst_instr", 32'(instr), 32'h0000);
    check("async_rst_stack_err", 32'(stack_err), 32'h0);
    instr_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_pc", 32'(instr_pc), 32'h000);
    check("post_rst_valid", 32'(instr_valid), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
